// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory handshake ports of the multicycle Hack core.
// Each port holds its request and payload steady until the matching ack is sampled.
interface hack_cpu_mc_if #(
    parameter int DW = 16,
    parameter int AW = 15
);
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          imem_ack;

    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata;
    logic          dmem_ack;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU: 16-bit A/C instructions on a DW-bit datapath, with
// handshaked instruction/data memories, a retire strobe and self-jump halt.
//
// state | meaning
// BOOT  | first cycle out of reset, all outputs idle
// FETCH | imem_req high at PC, wait for imem_ack
// DEC   | decode ir; A-instructions commit here
// MRD   | dmem read at pre-instruction A, wait for dmem_ack
// EXE   | ALU evaluate, latch wreg/flags; commit unless M is written
// MWR   | dmem write of wreg, commit on dmem_ack
// HALT  | stopped on a self-jump until reset
module hack_cpu_mc #(
    parameter int DW = 16,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          nrst,
    hack_cpu_mc_if.master bus,
    output logic          retire,
    output logic          halted
);
    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DEC,
        S_MRD,
        S_EXE,
        S_MWR,
        S_HALT
    } state_t;

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    state_t        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] d_reg;
    logic [DW-1:0] mdr;
    logic [DW-1:0] wreg;
    logic [15:0]   ir;
    logic          flag_lt;
    logic          flag_zr;

    logic [DW-1:0] alu_x;
    logic [DW-1:0] alu_y;
    logic [DW-1:0] alu_f;
    logic [DW-1:0] alu_r;
    logic [DW-1:0] c_res;
    logic          c_lt;
    logic          c_zr;
    logic          jump_taken;
    logic          self_jump;
    logic [AW-1:0] pc_next;

    always_comb begin
        alu_x = d_reg;
        alu_y = ir[12] ? mdr : a_reg;
        if (ir[11]) alu_x = '0;
        if (ir[10]) alu_x = ~alu_x;
        if (ir[9])  alu_y = '0;
        if (ir[8])  alu_y = ~alu_y;
        alu_f = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_r = ir[6] ? ~alu_f : alu_f;
    end

    // A write-back commits from the registered result; otherwise straight from the ALU.
    always_comb begin
        if (state == S_MWR) begin
            c_res = wreg;
            c_lt  = flag_lt;
            c_zr  = flag_zr;
        end else begin
            c_res = alu_r;
            c_lt  = alu_r[DW-1];
            c_zr  = (alu_r == '0);
        end
        jump_taken = ir[15] & ((ir[2] & c_lt) | (ir[1] & c_zr) | (ir[0] & ~c_lt & ~c_zr));
        self_jump  = ir[15] && (ir[2:0] == 3'b111) && (a_reg[AW-1:0] == pc);
        pc_next    = jump_taken ? a_reg[AW-1:0] : pc + PC_ONE;
        retire     = ((state == S_DEC) && !ir[15])
                  || ((state == S_EXE) && !ir[3])
                  || ((state == S_MWR) && bus.dmem_ack);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= S_BOOT;
            pc             <= '0;
            a_reg          <= '0;
            d_reg          <= '0;
            mdr            <= '0;
            wreg           <= '0;
            ir             <= '0;
            flag_lt        <= 1'b0;
            flag_zr        <= 1'b0;
            halted         <= 1'b0;
            bus.imem_req   <= 1'b0;
            bus.imem_addr  <= '0;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
        end else begin
            case (state)
                S_BOOT: begin
                    state         <= S_FETCH;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= pc;
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        ir           <= bus.imem_rdata;
                        bus.imem_req <= 1'b0;
                        state        <= S_DEC;
                    end
                end
                S_DEC: begin
                    if (ir[15]) begin
                        if (ir[12]) begin
                            state         <= S_MRD;
                            bus.dmem_req  <= 1'b1;
                            bus.dmem_we   <= 1'b0;
                            bus.dmem_addr <= a_reg[AW-1:0];
                        end else begin
                            state <= S_EXE;
                        end
                    end
                end
                S_MRD: begin
                    if (bus.dmem_ack) begin
                        mdr          <= bus.dmem_rdata;
                        bus.dmem_req <= 1'b0;
                        state        <= S_EXE;
                    end
                end
                S_EXE: begin
                    wreg    <= alu_r;
                    flag_lt <= alu_r[DW-1];
                    flag_zr <= (alu_r == '0);
                    if (ir[3]) begin
                        state          <= S_MWR;
                        bus.dmem_req   <= 1'b1;
                        bus.dmem_we    <= 1'b1;
                        bus.dmem_addr  <= a_reg[AW-1:0];
                        bus.dmem_wdata <= alu_r;
                    end
                end
                S_MWR: begin
                    if (bus.dmem_ack) begin
                        bus.dmem_req <= 1'b0;
                        bus.dmem_we  <= 1'b0;
                    end
                end
                S_HALT: begin
                end
                default: state <= S_BOOT;
            endcase

            // Commit point shared by DEC, EXE and MWR; overrides the next state above.
            if (retire) begin
                if (!ir[15]) begin
                    a_reg <= DW'(ir[14:0]);
                end else begin
                    if (ir[5]) a_reg <= c_res;
                    if (ir[4]) d_reg <= c_res;
                end
                pc <= pc_next;
                if (self_jump) begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end else begin
                    state         <= S_FETCH;
                    bus.imem_req  <= 1'b1;
                    bus.imem_addr <= pc_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc at DW=24/AW=12: memory models with optional
// random ack latency and a queue of expected data writes checked on each write ack.
module tb_hack_cpu_mc;
    localparam int DW    = 24;
    localparam int AW    = 12;
    localparam int MEM_N = 1 << AW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic nrst;
    logic retire;
    logic halted;

    int n_checks = 0;
    int n_errors = 0;
    int max_wait = 0;
    bit d_hold   = 1'b0;
    int retire_cnt = 0;
    int cyc        = 0;
    int ret6_cyc   = 0;
    bit started    = 1'b0;
    int k;
    int req_seen;

    logic [15:0]   imem [MEM_N];
    logic [DW-1:0] dmem [MEM_N];
    wr_t           exp_wr [$];

    hack_cpu_mc_if #(.DW(DW), .AW(AW)) bus ();

    hack_cpu_mc #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus    (bus.master),
        .retire (retire),
        .halted (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Retire and cycle monitor; cycle 1 is the first FETCH after reset.
    initial begin
        forever begin
            @(negedge clk);
            if (!nrst) begin
                retire_cnt = 0;
                cyc        = 0;
                ret6_cyc   = 0;
                started    = 1'b0;
            end else begin
                if (bus.imem_req) started = 1'b1;
                if (started) cyc++;
                if (retire) begin
                    retire_cnt++;
                    if (retire_cnt == 6) ret6_cyc = cyc;
                end
            end
        end
    end

    // Instruction memory responder.
    initial begin
        bit            busy;
        int            wcnt;
        logic [AW-1:0] cap_addr;
        busy = 1'b0;
        wcnt = 0;
        cap_addr = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (nrst && bus.imem_req) begin
                if (!busy) begin
                    busy     = 1'b1;
                    cap_addr = bus.imem_addr;
                    wcnt     = int'($urandom_range(max_wait, 0));
                end else begin
                    check("imem_addr_stable", bus.imem_addr, cap_addr);
                end
                if (wcnt == 0) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = imem[bus.imem_addr];
                    busy           = 1'b0;
                end else begin
                    bus.imem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                bus.imem_ack = 1'b0;
                busy         = 1'b0;
            end
        end
    end

    // Data memory responder; write acks are scored against exp_wr.
    initial begin
        bit            busy;
        int            wcnt;
        logic [AW-1:0] cap_addr;
        logic          cap_we;
        logic [DW-1:0] cap_wdata;
        wr_t           e;
        busy = 1'b0;
        wcnt = 0;
        cap_addr  = '0;
        cap_we    = 1'b0;
        cap_wdata = '0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (nrst && bus.dmem_req && !d_hold) begin
                if (!busy) begin
                    busy      = 1'b1;
                    cap_addr  = bus.dmem_addr;
                    cap_we    = bus.dmem_we;
                    cap_wdata = bus.dmem_wdata;
                    wcnt      = int'($urandom_range(max_wait, 0));
                end else begin
                    check("dmem_addr_stable", bus.dmem_addr, cap_addr);
                    check("dmem_we_stable", bus.dmem_we, cap_we);
                    if (cap_we) check("dmem_wdata_stable", bus.dmem_wdata, cap_wdata);
                end
                if (wcnt == 0) begin
                    bus.dmem_ack = 1'b1;
                    busy         = 1'b0;
                    if (bus.dmem_we) begin
                        check("wr_expected", exp_wr.size() > 0, 1);
                        if (exp_wr.size() > 0) begin
                            e = exp_wr.pop_front();
                            check("wr_addr", bus.dmem_addr, e.addr);
                            check("wr_data", bus.dmem_wdata, e.data);
                        end
                        dmem[bus.dmem_addr] = bus.dmem_wdata;
                    end else begin
                        bus.dmem_rdata = dmem[bus.dmem_addr];
                    end
                end else begin
                    bus.dmem_ack = 1'b0;
                    wcnt--;
                end
            end else begin
                bus.dmem_ack = 1'b0;
                busy         = 1'b0;
            end
        end
    end

    task automatic push_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_wr.push_back(e);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        nrst   = 1'b0;
        d_hold = 1'b0;
        for (int i = 0; i < MEM_N; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = '0;
        end
        exp_wr.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset(input string tag);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check({tag, "_boot_req"}, bus.imem_req, 0);
        @(posedge clk);
        #2;
        check({tag, "_fetch_req"}, bus.imem_req, 1);
        check({tag, "_fetch_addr"}, bus.imem_addr, 0);
    endtask

    task automatic wait_retires(input int n, input int budget, input string tag);
        int t;
        t = 0;
        while (retire_cnt < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        #2;
        check({tag, "_retire_reached"}, retire_cnt >= n, 1);
    endtask

    task automatic wait_halt(input int budget, input string tag);
        int t;
        t = 0;
        while (!halted && t < budget) begin
            @(posedge clk);
            t++;
        end
        #2;
        check({tag, "_halted"}, halted, 1);
    endtask

    task automatic load_sum_prog();
        imem[0] = 16'h0005;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0007;
        imem[3] = 16'hE090;
        imem[4] = 16'h0000;
        imem[5] = 16'hE308;
        imem[6] = 16'h0007;
        imem[7] = 16'hEA87;
        push_wr(12'd0, 24'd12);
    endtask

    initial begin
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_dmem_we", bus.dmem_we, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", dut.pc, 0);
        check("rst_a", dut.a_reg, 0);
        check("rst_d", dut.d_reg, 0);

        // Zero-wait sum program
        hold_reset();
        max_wait = 0;
        load_sum_prog();
        release_reset("sum0");
        wait_retires(6, 200, "sum0");
        check("sum0_cycles", ret6_cyc, 16);
        check("sum0_a", dut.a_reg, 0);
        check("sum0_d", dut.d_reg, 12);
        wait_halt(200, "sum0");
        check("sum0_pc", dut.pc, 7);
        check("sum0_m0", dmem[0], 12);
        check("sum0_wr_left", exp_wr.size(), 0);

        // Same program with random ack latency
        hold_reset();
        max_wait = 5;
        load_sum_prog();
        release_reset("sumr");
        wait_retires(6, 600, "sumr");
        check("sumr_a", dut.a_reg, 0);
        check("sumr_d", dut.d_reg, 12);
        wait_halt(600, "sumr");
        check("sumr_pc", dut.pc, 7);
        check("sumr_m0", dmem[0], 12);
        check("sumr_wr_left", exp_wr.size(), 0);
        max_wait = 0;

        // Taken JGT back to its own address
        hold_reset();
        imem[0] = 16'h000A;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0003;
        imem[3] = 16'hE301;
        release_reset("jgt");
        wait_retires(4, 200, "jgt");
        check("jgt_pc", dut.pc, 3);
        check("jgt_d", dut.d_reg, 10);

        // AM=D-1;JMP: address and target use the old A
        hold_reset();
        imem[0]  = 16'h000A;
        imem[1]  = 16'hEC10;
        imem[2]  = 16'h0014;
        imem[3]  = 16'hE3AF;
        imem[20] = 16'h0015;
        imem[21] = 16'hEA87;
        push_wr(12'd20, 24'd9);
        release_reset("amjmp");
        wait_retires(4, 200, "amjmp");
        check("amjmp_pc", dut.pc, 20);
        check("amjmp_a", dut.a_reg, 9);
        check("amjmp_d", dut.d_reg, 10);
        wait_halt(200, "amjmp");
        check("amjmp_halt_pc", dut.pc, 21);
        check("amjmp_m20", dmem[20], 9);
        check("amjmp_wr_left", exp_wr.size(), 0);

        // Read-modify-write and read-only C-instructions
        hold_reset();
        imem[0] = 16'h0003;
        imem[1] = 16'hFDC8;
        imem[2] = 16'h0004;
        imem[3] = 16'hFC10;
        imem[4] = 16'h0005;
        imem[5] = 16'hEA87;
        dmem[3] = 24'd41;
        dmem[4] = 24'd100;
        push_wr(12'd3, 24'd42);
        release_reset("rmw");
        wait_retires(6, 200, "rmw");
        check("rmw_cycles", ret6_cyc, 18);
        check("rmw_d", dut.d_reg, 100);
        check("rmw_m3", dmem[3], 42);
        check("rmw_wr_left", exp_wr.size(), 0);

        // Self-jump halt
        hold_reset();
        imem[0] = 16'h0001;
        imem[1] = 16'hEA87;
        release_reset("self");
        wait_halt(100, "self");
        req_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #2;
            if (bus.imem_req) req_seen++;
        end
        check("self_retires", retire_cnt, 2);
        check("self_req_idle", req_seen, 0);
        check("self_pc", dut.pc, 1);
        check("self_still_halted", halted, 1);

        // 24-bit datapath: 0x7FFF+1 stays positive
        hold_reset();
        imem[0] = 16'h7FFF;
        imem[1] = 16'hEC10;
        imem[2] = 16'hE7D0;
        imem[3] = 16'h0004;
        imem[4] = 16'hEA87;
        release_reset("wide");
        wait_retires(3, 200, "wide");
        check("wide_d", dut.d_reg, 24'h008000);
        check("wide_lt", dut.flag_lt, 0);
        wait_halt(200, "wide");

        // PC wrap at 2^AW
        hold_reset();
        imem[0]    = 16'h0FFF;
        imem[1]    = 16'hEA87;
        imem[4095] = 16'h0000;
        release_reset("wrap");
        wait_retires(2, 200, "wrap_jmp");
        check("wrap_pc_top", dut.pc, 12'hFFF);
        wait_retires(3, 200, "wrap_fall");
        check("wrap_pc_zero", dut.pc, 0);
        check("wrap_a", dut.a_reg, 0);

        // Reset while a write waits for its ack
        hold_reset();
        imem[0] = 16'h000A;
        imem[1] = 16'hEC10;
        imem[2] = 16'h0014;
        imem[3] = 16'hE308;
        d_hold  = 1'b1;
        release_reset("mwr");
        k = 0;
        while (!(bus.dmem_req && bus.dmem_we) && k < 100) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("mwr_reached", bus.dmem_req && bus.dmem_we, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("mwr_rst_dmem_req", bus.dmem_req, 0);
        check("mwr_rst_dmem_we", bus.dmem_we, 0);
        check("mwr_rst_retire", retire, 0);
        check("mwr_rst_pc", dut.pc, 0);
        check("mwr_rst_a", dut.a_reg, 0);
        check("mwr_rst_d", dut.d_reg, 0);
        check("mwr_no_write", dmem[20], 0);
        repeat (2) @(negedge clk);
        d_hold  = 1'b0;
        imem[4] = 16'h0005;
        imem[5] = 16'hEA87;
        push_wr(12'd20, 24'd10);
        release_reset("mwr_restart");
        check("mwr_restart_a", dut.a_reg, 0);
        check("mwr_restart_d", dut.d_reg, 0);
        wait_halt(200, "mwr_restart");
        check("mwr_restart_pc", dut.pc, 5);
        check("mwr_restart_m20", dmem[20], 10);
        check("mwr_restart_wr_left", exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
